// File: rtl/sync_event_pkg.sv
// Shared constants for the event-synchronizer transmit side: FSM encoding and phase counter width.
package sync_event_pkg;

    localparam int CNT_WIDTH = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HIGH = 2'd1,
        ST_LOW  = 2'd2
    } state_t;

endpackage

// File: rtl/sync_event_tx_chan.sv
// One transmit channel: stretches queued event requests into HIGH/LOW-timed level pulses.
// Optional sticky saturation flag when SYNC_EVENT_TX_OVERFLOW_EN is defined.
module sync_event_tx_chan
    import sync_event_pkg::*;
#(
    parameter int HIGH_CYCLES = 4,
    parameter int LOW_CYCLES  = 4,
    parameter int PEND_WIDTH  = 4
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic       in_event,
`ifdef SYNC_EVENT_TX_OVERFLOW_EN
    input  logic       overflow_clr,
    output logic       overflow,
`endif
    output logic       out_event,
    output logic [1:0] state,
    output logic       pend_nz
);

    localparam logic [CNT_WIDTH-1:0]  HIGH_LOAD = CNT_WIDTH'(HIGH_CYCLES - 1);
    localparam logic [CNT_WIDTH-1:0]  LOW_LOAD  = CNT_WIDTH'(LOW_CYCLES - 1);
    localparam logic [CNT_WIDTH-1:0]  CNT_ONE   = CNT_WIDTH'(1);
    localparam logic [PEND_WIDTH-1:0] PEND_ONE  = PEND_WIDTH'(1);
    localparam logic [PEND_WIDTH-1:0] PEND_MAX  = '1;

    state_t                st;
    logic [CNT_WIDTH-1:0]  cnt;
    logic [PEND_WIDTH-1:0] pending;
    logic                  req;
    logic                  consume;
    logic                  drop;

    assign req     = in_event | (pending != '0);
    assign consume = req & ((st == ST_IDLE) | ((st == ST_LOW) & (cnt == '0)));
    assign drop    = in_event & ~consume & (pending == PEND_MAX);
    assign state   = st;
    assign pend_nz = (pending != '0);

    always_ff @(posedge clk) begin
        if (!resetn) begin
            st        <= ST_IDLE;
            cnt       <= '0;
            pending   <= '0;
            out_event <= 1'b0;
        end else begin
            case (st)
                ST_IDLE: begin
                    if (req) begin
                        st        <= ST_HIGH;
                        cnt       <= HIGH_LOAD;
                        out_event <= 1'b1;
                    end
                end
                ST_HIGH: begin
                    if (cnt == '0) begin
                        st        <= ST_LOW;
                        cnt       <= LOW_LOAD;
                        out_event <= 1'b0;
                    end else begin
                        cnt <= cnt - CNT_ONE;
                    end
                end
                ST_LOW: begin
                    if (cnt != '0) begin
                        cnt <= cnt - CNT_ONE;
                    end else if (req) begin
                        st        <= ST_HIGH;
                        cnt       <= HIGH_LOAD;
                        out_event <= 1'b1;
                    end else begin
                        st <= ST_IDLE;
                    end
                end
                default: begin
                    st        <= ST_IDLE;
                    cnt       <= '0;
                    out_event <= 1'b0;
                end
            endcase

            // A coincident arrival and consume leaves the queue depth unchanged.
            if (in_event && !consume && !drop) begin
                pending <= pending + PEND_ONE;
            end else if (!in_event && consume) begin
                pending <= pending - PEND_ONE;
            end
        end
    end

`ifdef SYNC_EVENT_TX_OVERFLOW_EN
    always_ff @(posedge clk) begin
        if (!resetn) begin
            overflow <= 1'b0;
        end else begin
            overflow <= (overflow & ~overflow_clr) | drop;
        end
    end
`endif

endmodule

// File: rtl/sync_event_tx.sv
// Source-domain event stretcher: NUM_OF_EVENTS independent channels feeding a CDC receiver.
// Define SYNC_EVENT_TX_OVERFLOW_EN to add the sticky overflow / overflow_clr ports.
module sync_event_tx
    import sync_event_pkg::*;
#(
    parameter int NUM_OF_EVENTS = 1,
    parameter int HIGH_CYCLES   = 4,
    parameter int LOW_CYCLES    = 4,
    parameter int PEND_WIDTH    = 4
) (
    input  logic                     clk,
    input  logic                     resetn,
    input  logic [NUM_OF_EVENTS-1:0] in_event,
`ifdef SYNC_EVENT_TX_OVERFLOW_EN
    input  logic [NUM_OF_EVENTS-1:0] overflow_clr,
    output logic [NUM_OF_EVENTS-1:0] overflow,
`endif
    output logic [NUM_OF_EVENTS-1:0] out_event,
    output logic [NUM_OF_EVENTS-1:0] busy
);

    for (genvar i = 0; i < NUM_OF_EVENTS; i++) begin : g_chan
        logic [1:0] chan_state;
        logic       chan_pend_nz;

        sync_event_tx_chan #(
            .HIGH_CYCLES (HIGH_CYCLES),
            .LOW_CYCLES  (LOW_CYCLES),
            .PEND_WIDTH  (PEND_WIDTH)
        ) u_chan (
            .clk          (clk),
            .resetn       (resetn),
            .in_event     (in_event[i]),
`ifdef SYNC_EVENT_TX_OVERFLOW_EN
            .overflow_clr (overflow_clr[i]),
            .overflow     (overflow[i]),
`endif
            .out_event    (out_event[i]),
            .state        (chan_state),
            .pend_nz      (chan_pend_nz)
        );

        assign busy[i] = (chan_state != ST_IDLE) | chan_pend_nz;
    end

endmodule

// File: tb/tb_sync_event_tx.sv
// Bench for sync_event_tx: directed scenarios feed an expected-pulse queue per channel; a negedge
// monitor pops and compares each rising edge and pulse width. Also models a slow-clock receiver.
`timescale 1ns/1ps
module tb_sync_event_tx;

    localparam int HIGH = 4;
    localparam int LOW  = 4;

    logic       clk = 1'b0;
    logic       oclk = 1'b0;
    logic       resetn;
    logic [1:0] in_event;
    logic [1:0] out_event;
    logic [1:0] busy;
    logic [0:0] sat_in;
    logic [0:0] sat_out;
    logic [0:0] sat_busy;
`ifdef SYNC_EVENT_TX_OVERFLOW_EN
    logic [1:0] ovf_clr;
    logic [1:0] ovf;
    logic [0:0] sat_ovf_clr;
    logic [0:0] sat_ovf;
`endif

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    // Per monitored channel: {rise cycle[31:8], width[7:0]}; channel 2 is the saturation DUT.
    logic [31:0] exp_q [3][$];
    logic [2:0]  track = 3'b111;
    logic [2:0]  prev = 3'b000;
    int          rise_at [3];
    int          exp_w [3];
    int          tx_pulses [3];

    logic s1 = 1'b0, s2 = 1'b0, s3 = 1'b0;
    int   rx_count = 0;

    always #5 clk = ~clk;
    always #16.5 oclk = ~oclk;
    always @(posedge clk) cyc <= cyc + 1;

    sync_event_tx #(
        .NUM_OF_EVENTS (2), .HIGH_CYCLES (HIGH), .LOW_CYCLES (LOW), .PEND_WIDTH (4)
    ) dut (
        .clk          (clk),
        .resetn       (resetn),
        .in_event     (in_event),
`ifdef SYNC_EVENT_TX_OVERFLOW_EN
        .overflow_clr (ovf_clr),
        .overflow     (ovf),
`endif
        .out_event    (out_event),
        .busy         (busy)
    );

    sync_event_tx #(
        .NUM_OF_EVENTS (1), .HIGH_CYCLES (HIGH), .LOW_CYCLES (LOW), .PEND_WIDTH (2)
    ) dut_sat (
        .clk          (clk),
        .resetn       (resetn),
        .in_event     (sat_in),
`ifdef SYNC_EVENT_TX_OVERFLOW_EN
        .overflow_clr (sat_ovf_clr),
        .overflow     (sat_ovf),
`endif
        .out_event    (sat_out),
        .busy         (sat_busy)
    );

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input int ch, input int rise, input int width);
        exp_q[ch].push_back({rise[23:0], width[7:0]});
    endtask

    task automatic wait_idle();
        int n = 0;
        while ((busy != 2'b00 || sat_busy != 1'b0) && n < 300) begin
            tick();
            n++;
        end
        check("idle_timeout", int'(n < 300), 1);
    endtask

    // Monitor: compares each rising edge and pulse width against the expected queue.
    always @(negedge clk) begin
        logic [2:0]  mon;
        logic [31:0] e;
        mon = {sat_out[0], out_event};
        for (int ch = 0; ch < 3; ch++) begin
            if (mon[ch] && !prev[ch]) begin
                rise_at[ch] = cyc;
                tx_pulses[ch]++;
                exp_w[ch] = HIGH;
                if (track[ch]) begin
                    check($sformatf("expected_pulse_ch%0d", ch), int'(exp_q[ch].size() > 0), 1);
                    if (exp_q[ch].size() > 0) begin
                        e = exp_q[ch].pop_front();
                        exp_w[ch] = int'(e[7:0]);
                        check($sformatf("rise_cycle_ch%0d", ch), cyc, int'(e[31:8]));
                    end
                end
            end
            if (!mon[ch] && prev[ch]) begin
                check($sformatf("pulse_width_ch%0d", ch), cyc - rise_at[ch], exp_w[ch]);
            end
        end
        prev = mon;
    end

    // Receiver model: two-flop sampler plus rising-edge detector on the slow clock.
    always @(posedge oclk) begin
        s1 <= out_event[0];
        s2 <= s1;
        s3 <= s2;
        if (s2 && !s3) rx_count <= rx_count + 1;
    end

    initial begin
        int t;
        int tx_base;
        int rx_base;
        int n;

        for (int ch = 0; ch < 3; ch++) begin
            rise_at[ch] = 0;
            exp_w[ch] = HIGH;
            tx_pulses[ch] = 0;
        end
        resetn = 1'b0;
        in_event = 2'b00;
        sat_in = 1'b0;
`ifdef SYNC_EVENT_TX_OVERFLOW_EN
        ovf_clr = 2'b00;
        sat_ovf_clr = 1'b0;
`endif
        repeat (3) tick();
        check("reset_out_event", int'(out_event), 0);
        check("reset_busy", int'(busy), 0);
        check("reset_sat_busy", int'(sat_busy), 0);
`ifdef SYNC_EVENT_TX_OVERFLOW_EN
        check("reset_overflow", int'(sat_ovf), 0);
`endif
        resetn = 1'b1;
        repeat (2) tick();

        // Single event on ch0: high t+1..t+4, busy through t+8.
        t = cyc;
        push(0, t + 1, HIGH);
        for (int k = 0; k <= 10; k++) begin
            in_event[0] = (k == 0);
            if (k == 1) check("single_busy_rise", int'(busy[0]), 1);
            if (k == 8) check("single_busy_last", int'(busy[0]), 1);
            if (k == 9) check("single_busy_fall", int'(busy[0]), 0);
            tick();
        end
        wait_idle();

        // Burst of 3 on ch1: rises t+1, t+9, t+17; busy falls at t+25; ch0 stays quiet.
        t = cyc;
        push(1, t + 1, HIGH);
        push(1, t + 9, HIGH);
        push(1, t + 17, HIGH);
        for (int k = 0; k <= 26; k++) begin
            in_event[1] = (k < 3);
            if (k == 24) check("burst_busy_last", int'(busy[1]), 1);
            if (k == 25) check("burst_busy_fall", int'(busy[1]), 0);
            if (k == 12) check("burst_ch0_idle", int'(busy[0]), 0);
            tick();
        end
        wait_idle();

        // Event in the last LOW cycle: straight back to HIGH, no IDLE gap, no queue left.
        t = cyc;
        push(0, t + 1, HIGH);
        push(0, t + 9, HIGH);
        for (int k = 0; k <= 18; k++) begin
            in_event[0] = (k == 0 || k == 8);
            if (k == 9) check("boundary_out_high", int'(out_event[0]), 1);
            if (k == 16) check("boundary_busy_last", int'(busy[0]), 1);
            if (k == 17) check("boundary_busy_fall", int'(busy[0]), 0);
            tick();
        end
        wait_idle();

        // Saturation with PEND_WIDTH=2: 8 requests give exactly 4 pulses.
        t = cyc;
        push(2, t + 1, HIGH);
        push(2, t + 9, HIGH);
        push(2, t + 17, HIGH);
        push(2, t + 25, HIGH);
        for (int k = 0; k <= 34; k++) begin
            sat_in[0] = (k < 8);
`ifdef SYNC_EVENT_TX_OVERFLOW_EN
            sat_ovf_clr[0] = (k == 10);
            if (k == 4) check("ovf_before_drop", int'(sat_ovf), 0);
            if (k == 5) check("ovf_set", int'(sat_ovf), 1);
            if (k == 10) check("ovf_sticky", int'(sat_ovf), 1);
            if (k == 11) check("ovf_cleared", int'(sat_ovf), 0);
`endif
            if (k == 32) check("sat_busy_last", int'(sat_busy), 1);
            if (k == 33) check("sat_busy_fall", int'(sat_busy), 0);
            tick();
        end
        wait_idle();

        // Reset in the 2nd HIGH cycle of the 2nd pulse (pending=3) aborts everything.
        t = cyc;
        push(0, t + 1, HIGH);
        push(0, t + 9, 2);
        for (int k = 0; k <= 45; k++) begin
            in_event[0] = (k < 5);
            resetn = (k != 10);
            if (k == 10) check("pre_reset_busy", int'(busy[0]), 1);
            if (k == 11) check("abort_out_event", int'(out_event[0]), 0);
            if (k == 11) check("abort_busy", int'(busy[0]), 0);
            if (k == 45) check("after_reset_busy", int'(busy[0]), 0);
            tick();
        end
        wait_idle();

        // CDC: 20 events with random gaps into a receiver clocked 3.3x slower.
        repeat (10) @(posedge oclk);
        #1;
        track[0] = 1'b0;
        tx_base = tx_pulses[0];
        rx_base = rx_count;
        for (int e = 0; e < 20; e++) begin
            in_event[0] = 1'b1;
            tick();
            in_event[0] = 1'b0;
            repeat ($urandom_range(2, 12)) tick();
        end
        n = 0;
        while (busy[0] && n < 1000) begin
            tick();
            n++;
        end
        check("cdc_idle_timeout", int'(n < 1000), 1);
        repeat (6) @(posedge oclk);
        #1;
        check("cdc_tx_pulses", tx_pulses[0] - tx_base, 20);
        check("cdc_rx_pulses", rx_count - rx_base, 20);

        for (int ch = 0; ch < 3; ch++) begin
            check($sformatf("leftover_expect_ch%0d", ch), exp_q[ch].size(), 0);
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
